mtr_spd_ramp: RTL
=================

// Module: mtr_spd_ramp
// PURPOSE
//  Slew-rate limiter between the speed controller and the motor driver: turns raw 12-bit signed
//  lft/rght speed commands into ramped lft_spd/rght_spd for the H-bridge PWM stage. Limits
//  current spikes (and so over-current trips downstream) by stepping speed once per tick.
//  Every reversal passes through a zero-speed dwell.
// PARAMETERS
//  STEP       16    max |change| of each output per tick (1..2047)
//  TICK_DIV   2048  clk cycles per ramp tick (2..65535); 2048 = one 11-bit PWM period
//  REV_DWELL  4     ticks held at zero before a sign reversal continues (0 = no dwell)
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous, active-high reset
//  lft_cmd    in   12  signed target speed, left (negative = reverse)
//  rght_cmd   in   12  signed target speed, right
//  cmd_vld    in   1   1-cycle strobe: capture lft_cmd/rght_cmd as new targets
//  lft_spd    out  12  signed ramped speed to motor driver, left (registered)
//  rght_spd   out  12  signed ramped speed to motor driver, right (registered)
//  ramp_busy  out  1   1 while either channel is != its target or in DWELL (registered)
//  estop      in   1   only with MTR_SPD_RAMP_ESTOP_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge): tick_cnt=0, both targets=0, both outputs=0, both FSMs=TRACK,
//   dwell_cnt=0, ramp_busy=0. rst overrides every other input in the same cycle.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where tick_cnt==TICK_DIV-1.
//  Target capture: on cmd_vld, target<=cmd, with -2048 clamped to -2047 (symmetric range).
//   cmd_vld in a tick cycle: that tick uses the OLD target; the new target acts from the next tick.
//  Per-channel FSM, evaluated only on tick (independent per channel):
//   TRACK: if cur!=0 and sign(tgt)!=sign(cur) and tgt!=0, step toward 0 by min(STEP,|cur|).
//          On reaching 0 -> DWELL with dwell_cnt=REV_DWELL (skip DWELL if REV_DWELL=0).
//          Otherwise step toward tgt by min(STEP,|tgt-cur|). A step never overshoots.
//   DWELL: output held at 0; dwell_cnt decrements each tick; leave at 0 -> TRACK.
//          The first ramp step is on the tick after the exit tick.
//          A new target of the same sign as before, or 0: stay in DWELL until done.
//  Arithmetic: diff computed 13-bit signed (no overflow at +/-2047). Outputs always in [-2047,2047].
//  Stepping to 0 from a sign-matched target (tgt=0) is a plain ramp; no DWELL.
//  ramp_busy = (lft_spd!=lft_tgt)|(rght_spd!=rght_tgt)|any DWELL; updates the cycle after the
//   state change.
//  Latency: output changes the cycle after the tick. A capture-to-first-step takes
//   <= TICK_DIV+1 cycles.
// CONFIGURATION
//  MTR_SPD_RAMP_ESTOP_EN defined: adds input estop (synchronous, active-high).
//   While estop=1: both outputs forced to 0 in the next cycle (no ramp, no DWELL), FSMs=TRACK,
//   targets=0, cmd_vld ignored. After estop falls, outputs stay 0 until a new cmd_vld.
//  Not defined: no estop port; stopping is only by cmd 0 through the normal ramp.
// TESTING (bench: TICK_DIV=4, STEP=16, REV_DWELL=4)
//  1 rst=1 with cmd_vld=1, lft_cmd=500 -> lft_spd=rght_spd=0, ramp_busy=0; target stays 0.
//  2 cmd lft=+100 from 0 -> lft_spd 16,32,48,64,80,96,100 on successive ticks.
//    ramp_busy falls 1 cycle after 100; rght_spd stays 0.
//  3 lft at +32, cmd -40 -> 16,0, then 4 ticks at 0 (DWELL), then -16,-32,-40.
//    No tick ever shows a positive-to-negative jump.
//  4 cmd rght=-2048 from 0 -> target -2047; 128 ticks to reach -2047; never -2048.
//  5 cmd_vld exactly on a tick cycle with new tgt=+64 (old tgt=0, cur=0) -> no step that tick;
//    +16 on next tick.
//  6 (ESTOP_EN) lft at +800, estop=1 mid-ramp -> lft_spd=0 next cycle; estop=0 -> holds 0;
//    cmd_vld +48 -> 16,32,48.

Source files
------------

// File: rtl/mtr_spd_ramp.sv
// mtr_spd_ramp: slew-rate limiter between the speed controller and the H-bridge
// PWM stage. Each channel steps toward its target by at most STEP once per ramp
// tick, and a sign reversal always ramps down to zero and dwells there first.
// Optional feature macro: MTR_SPD_RAMP_ESTOP_EN adds a synchronous estop input
// that forces both outputs to zero and clears the targets.
//
//   state | meaning
//   TRACK | ramping toward the target (toward 0 first when the sign must flip)
//   DWELL | held at zero for REV_DWELL ticks in the middle of a reversal
module mtr_spd_ramp #(
  parameter int STEP      = 16,
  parameter int TICK_DIV  = 2048,
  parameter int REV_DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MTR_SPD_RAMP_ESTOP_EN
  input  logic               estop,
`endif
  input  logic signed [11:0] lft_cmd,
  input  logic signed [11:0] rght_cmd,
  input  logic               cmd_vld,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               ramp_busy
);

  typedef enum logic {TRACK, DWELL} state_t;

  localparam logic signed [12:0] STEP_S     = 13'(STEP);
  localparam logic [15:0]        TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [15:0]        DWELL_INIT = 16'(REV_DWELL);

  logic [15:0]        tick_cnt;
  logic               tick;
  logic               busy;
  logic signed [11:0] cmd       [2];
  logic signed [11:0] tgt       [2];
  logic signed [11:0] spd       [2];
  logic signed [11:0] nxt_spd   [2];
  state_t             st        [2];
  state_t             nxt_st    [2];
  logic [15:0]        dwell_cnt [2];
  logic [15:0]        nxt_dwell [2];

  assign cmd[0]    = lft_cmd;
  assign cmd[1]    = rght_cmd;
  assign tick      = (tick_cnt == TICK_LAST);
  assign lft_spd   = spd[0];
  assign rght_spd  = spd[1];
  assign ramp_busy = busy;

  // One bounded step from cur toward goal; the 13-bit diff cannot overflow and
  // the step lands exactly on goal when it is within STEP, so it never overshoots.
  function automatic logic signed [11:0] step_toward(input logic signed [11:0] cur,
                                                     input logic signed [11:0] goal);
    logic signed [12:0] cur_x;
    logic signed [12:0] diff;
    cur_x = {cur[11], cur};
    diff  = {goal[11], goal} - cur_x;
    if (diff > STEP_S)
      step_toward = 12'(cur_x + STEP_S);
    else if (diff < -STEP_S)
      step_toward = 12'(cur_x - STEP_S);
    else
      step_toward = goal;
  endfunction

  // Next-tick speed, state and dwell count for each channel.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      nxt_spd[c]   = spd[c];
      nxt_st[c]    = st[c];
      nxt_dwell[c] = dwell_cnt[c];
      case (st[c])
        TRACK: begin
          if ((spd[c] != 12'sd0) && (tgt[c] != 12'sd0) && (tgt[c][11] != spd[c][11])) begin
            nxt_spd[c] = step_toward(spd[c], 12'sd0);
            if ((step_toward(spd[c], 12'sd0) == 12'sd0) && (REV_DWELL != 0)) begin
              nxt_st[c]    = DWELL;
              nxt_dwell[c] = DWELL_INIT;
            end
          end else begin
            nxt_spd[c] = step_toward(spd[c], tgt[c]);
          end
        end
        DWELL: begin
          // The dwell always runs to completion, whatever the target does meanwhile.
          nxt_spd[c] = 12'sd0;
          if (dwell_cnt[c] <= 16'd1) begin
            nxt_st[c]    = TRACK;
            nxt_dwell[c] = 16'd0;
          end else begin
            nxt_dwell[c] = dwell_cnt[c] - 16'd1;
          end
        end
        default: begin
          nxt_spd[c]   = 12'sd0;
          nxt_st[c]    = TRACK;
          nxt_dwell[c] = 16'd0;
        end
      endcase
    end
  end

  // Tick divider, target capture, per-channel FSM update and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= 16'd0;
      busy     <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        tgt[c]       <= 12'sd0;
        spd[c]       <= 12'sd0;
        st[c]        <= TRACK;
        dwell_cnt[c] <= 16'd0;
      end
    end else begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
`ifdef MTR_SPD_RAMP_ESTOP_EN
      if (estop) begin
        busy <= 1'b0;
        for (int c = 0; c < 2; c++) begin
          tgt[c]       <= 12'sd0;
          spd[c]       <= 12'sd0;
          st[c]        <= TRACK;
          dwell_cnt[c] <= 16'd0;
        end
      end else begin
`else
      begin
`endif
        busy <= (spd[0] != tgt[0]) || (spd[1] != tgt[1]) || (st[0] == DWELL) || (st[1] == DWELL);
        for (int c = 0; c < 2; c++) begin
          // -2048 has no positive mirror, so keep the target range symmetric.
          if (cmd_vld)
            tgt[c] <= (cmd[c] == 12'sh800) ? 12'sh801 : cmd[c];
          if (tick) begin
            spd[c]       <= nxt_spd[c];
            st[c]        <= nxt_st[c];
            dwell_cnt[c] <= nxt_dwell[c];
          end
        end
      end
    end
  end

endmodule
